// File: rtl/pacman_sprite_draw.sv
// rtl/pacman_sprite_draw.sv - Pac-Man per-pixel renderer feeding the 32x32 font ROM (optional PAC_HFLIP_EN)
module pacman_sprite_draw #(
    parameter int SPR_SIZE = 32,
    parameter int ANIM_DIV = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  PacX,
    input  logic [9:0]  PacY,
    input  logic [1:0]  dir,
    input  logic        moving,
    output logic [7:0]  font_addr,
    input  logic [31:0] font_data,
    output logic        pac_on,
    output logic        mouth_open
);

    typedef enum logic {
        ST_CLOSED = 1'b0,
        ST_OPEN   = 1'b1
    } anim_state_t;

    localparam logic [3:0]  ANIM_LAST = 4'(ANIM_DIV - 1);
    localparam logic [10:0] SPR_LIM   = 11'(SPR_SIZE);

    anim_state_t state;
    logic [3:0]  anim_cnt;

    logic [9:0]  xs;
    logic [9:0]  ys;
    logic [1:0]  dir_s;

    logic [10:0] dx;
    logic [10:0] dy;
    logic        in_box;
    logic [2:0]  spr_idx;

    logic        in_box_r;
    logic [4:0]  row_r;
    logic [4:0]  col_r;
    logic [2:0]  idx_r;
    logic [4:0]  pix_bit;

`ifdef PAC_HFLIP_EN
    logic        flip;
    logic        flip_r;
`endif

    // Shadow copies of position and facing, updated only at the frame boundary so the sprite never tears
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            xs    <= '0;
            ys    <= '0;
            dir_s <= '0;
        end else if (frame_tick) begin
            xs    <= PacX;
            ys    <= PacY;
            dir_s <= dir;
        end
    end

    // Mouth animation: the moving flag being captured on this tick decides whether the counter advances
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_OPEN;
            anim_cnt <= '0;
        end else if (frame_tick) begin
            if (!moving) begin
                state <= ST_OPEN;
            end else if (anim_cnt == ANIM_LAST) begin
                anim_cnt <= '0;
                state    <= (state == ST_OPEN) ? ST_CLOSED : ST_OPEN;
            end else begin
                anim_cnt <= anim_cnt + 4'd1;
            end
        end
    end

    assign mouth_open = (state == ST_OPEN);

    // Unsigned differences: a sprite left of / above the beam wraps to a large value and fails the box test
    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, xs};
        dy     = {1'b0, DrawY} - {1'b0, ys};
        in_box = (dx < SPR_LIM) && (dy < SPR_LIM);
    end

    // Sprite slot selection: closed mouth shares one slot, open mouth uses one slot per facing
    always_comb begin
        spr_idx = 3'd4;
`ifdef PAC_HFLIP_EN
        flip = 1'b0;
        if (state == ST_OPEN) begin
            if (dir_s == 2'd1) begin
                spr_idx = 3'd0;
                flip    = 1'b1;
            end else begin
                spr_idx = {1'b0, dir_s};
            end
        end
`else
        if (state == ST_OPEN) begin
            spr_idx = {1'b0, dir_s};
        end
`endif
    end

    // Stage 1: register box hit, row/column within the sprite and the slot to fetch
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in_box_r <= 1'b0;
            row_r    <= '0;
            col_r    <= '0;
            idx_r    <= '0;
`ifdef PAC_HFLIP_EN
            flip_r   <= 1'b0;
`endif
        end else begin
            in_box_r <= in_box;
            row_r    <= dy[4:0];
            col_r    <= dx[4:0];
            idx_r    <= spr_idx;
`ifdef PAC_HFLIP_EN
            flip_r   <= flip;
`endif
        end
    end

    assign font_addr = {idx_r, row_r};

    // Bit 31 is the leftmost pixel, so column c normally reads bit 31-c; a mirrored sprite reads bit c
    always_comb begin
`ifdef PAC_HFLIP_EN
        pix_bit = flip_r ? col_r : ~col_r;
`else
        pix_bit = ~col_r;
`endif
    end

    // Stage 2: pick the pixel out of the returned ROM row
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pac_on <= 1'b0;
        end else begin
            pac_on <= in_box_r & font_data[pix_bit];
        end
    end

endmodule

// File: tb/tb_pacman_sprite_draw.sv
// tb/tb_pacman_sprite_draw.sv - directed self-checking bench for pacman_sprite_draw
module tb_pacman_sprite_draw;

    logic        Clk;
    logic        Reset_n;
    logic        frame_tick;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [9:0]  PacX;
    logic [9:0]  PacY;
    logic [1:0]  dir;
    logic        moving;
    logic [7:0]  font_addr;
    logic [31:0] font_data;
    logic        pac_on;
    logic        mouth_open;

    int total = 0;
    int bad   = 0;

    pacman_sprite_draw dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_tick (frame_tick),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .PacX       (PacX),
        .PacY       (PacY),
        .dir        (dir),
        .moving     (moving),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .pac_on     (pac_on),
        .mouth_open (mouth_open)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ROM stand-in: two hand-drawn rows, everything else fully lit
    always_comb begin
        case (font_addr)
            8'd16:   font_data = 32'h1FFF_0000;
            8'd116:  font_data = 32'h0020_0000;
            default: font_data = 32'hFFFF_FFFF;
        endcase
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic probe(input logic [9:0] x, input logic [9:0] y, output logic o);
        DrawX = x;
        DrawY = y;
        step();
        step();
        o = pac_on;
    endtask

    task automatic test_reset();
        logic o;
        Reset_n = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
        probe(10'd5, 10'd5, o);
        total++;
        if (o !== 1'b1) begin bad++; $display("FAIL reset_pre_lit: got %b want 1", o); end
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        total++;
        if (pac_on !== 1'b0) begin bad++; $display("FAIL reset_async_pac_on: got %b want 0", pac_on); end
        total++;
        if (font_addr !== 8'd0) begin bad++; $display("FAIL reset_font_addr: got %0d want 0", font_addr); end
        total++;
        if (mouth_open !== 1'b1) begin bad++; $display("FAIL reset_mouth_open: got %b want 1", mouth_open); end
        step();
        step();
        step();
        Reset_n = 1'b1;
        step();
        total++;
        if (pac_on !== 1'b0) begin bad++; $display("FAIL reset_first_cycle: got %b want 0", pac_on); end
        step();
        total++;
        if (pac_on !== 1'b1) begin bad++; $display("FAIL reset_second_cycle: got %b want 1", pac_on); end
    endtask

    task automatic test_scan_row();
        logic exp;
        int   x;
        PacX   = 10'd100;
        PacY   = 10'd200;
        dir    = 2'd0;
        moving = 1'b0;
        pulse_tick();
        DrawY = 10'd216;
        for (int i = 0; i <= 40; i++) begin
            DrawX = 10'(96 + i);
            step();
            if (i == 1) begin
                total++;
                if (font_addr !== 8'd16) begin bad++; $display("FAIL scan_font_addr: got %0d want 16", font_addr); end
            end
            if (i >= 1) begin
                x = 96 + i - 1;
                exp = (x >= 103 && x <= 115);
                total++;
                if (pac_on !== exp) begin bad++; $display("FAIL scan_x%0d: got %b want %b", x, pac_on, exp); end
            end
        end
    endtask

    task automatic test_anim();
        logic [11:0] seq;
        seq    = 12'b1110_0001_1110;
        DrawX  = 10'd110;
        DrawY  = 10'd210;
        moving = 1'b1;
        for (int t = 0; t < 12; t++) begin
            pulse_tick();
            total++;
            if (mouth_open !== seq[11 - t]) begin bad++; $display("FAIL anim_tick%0d: got %b want %b", t + 1, mouth_open, seq[11 - t]); end
            step();
            total++;
            if (font_addr[7:5] !== (seq[11 - t] ? 3'd0 : 3'd4)) begin
                bad++; $display("FAIL anim_idx%0d: got %0d want %0d", t + 1, font_addr[7:5], seq[11 - t] ? 3'd0 : 3'd4);
            end
        end
    endtask

    task automatic test_freeze();
        pulse_tick();
        pulse_tick();
        total++;
        if (mouth_open !== 1'b0) begin bad++; $display("FAIL freeze_pre: got %b want 0", mouth_open); end
        moving = 1'b0;
        pulse_tick();
        total++;
        if (mouth_open !== 1'b1) begin bad++; $display("FAIL freeze_forced_open: got %b want 1", mouth_open); end
        pulse_tick();
        total++;
        if (mouth_open !== 1'b1) begin bad++; $display("FAIL freeze_hold: got %b want 1", mouth_open); end
        moving = 1'b1;
        pulse_tick();
        total++;
        if (mouth_open !== 1'b1) begin bad++; $display("FAIL freeze_resume1: got %b want 1", mouth_open); end
        pulse_tick();
        total++;
        if (mouth_open !== 1'b0) begin bad++; $display("FAIL freeze_resume2: got %b want 0", mouth_open); end
        moving = 1'b0;
        pulse_tick();
        total++;
        if (mouth_open !== 1'b1) begin bad++; $display("FAIL freeze_reopen: got %b want 1", mouth_open); end
    endtask

    task automatic test_dir_down();
        PacX = 10'd100;
        PacY = 10'd200;
        dir  = 2'd3;
        pulse_tick();
        DrawX = 10'd110;
        DrawY = 10'd220;
        step();
        total++;
        if (font_addr !== 8'd116) begin bad++; $display("FAIL down_font_addr: got %0d want 116", font_addr); end
        DrawX = 10'd111;
        step();
        total++;
        if (pac_on !== 1'b1) begin bad++; $display("FAIL down_bit21: got %b want 1", pac_on); end
        step();
        total++;
        if (pac_on !== 1'b0) begin bad++; $display("FAIL down_bit20: got %b want 0", pac_on); end
    endtask

    task automatic test_no_tear_and_edge();
        logic o;
        PacX = 10'd100;
        PacY = 10'd200;
        dir  = 2'd0;
        pulse_tick();
        PacX = 10'd300;
        probe(10'd110, 10'd216, o);
        total++;
        if (o !== 1'b1) begin bad++; $display("FAIL tear_old_pos: got %b want 1", o); end
        probe(10'd310, 10'd216, o);
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL tear_new_early: got %b want 0", o); end
        pulse_tick();
        probe(10'd310, 10'd216, o);
        total++;
        if (o !== 1'b1) begin bad++; $display("FAIL tear_new_pos: got %b want 1", o); end
        probe(10'd110, 10'd216, o);
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL tear_old_gone: got %b want 0", o); end
        PacX = 10'd620;
        pulse_tick();
        probe(10'd619, 10'd210, o);
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL edge_x619: got %b want 0", o); end
        probe(10'd620, 10'd210, o);
        total++;
        if (o !== 1'b1) begin bad++; $display("FAIL edge_x620: got %b want 1", o); end
        probe(10'd639, 10'd210, o);
        total++;
        if (o !== 1'b1) begin bad++; $display("FAIL edge_x639: got %b want 1", o); end
        probe(10'd0, 10'd210, o);
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL edge_wrap_x0: got %b want 0", o); end
        probe(10'd5, 10'd210, o);
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL edge_wrap_x5: got %b want 0", o); end
        probe(10'd630, 10'd199, o);
        total++;
        if (o !== 1'b0) begin bad++; $display("FAIL edge_above: got %b want 0", o); end
    endtask

    initial begin
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        DrawX      = '0;
        DrawY      = '0;
        PacX       = '0;
        PacY       = '0;
        dir        = '0;
        moving     = 1'b0;
        test_reset();
        test_scan_row();
        test_anim();
        test_freeze();
        test_dir_down();
        test_no_tear_and_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pacman_sprite_draw.md
Name: pacman_sprite_draw

Overview:
- Per-pixel Pac-Man renderer that sits directly upstream of the 32x32 Pac-Man font ROM (8-bit row address in, 32-bit row bitmap out, combinational).
- Converts the VGA scan position plus the Pac-Man position, direction and motion state into a ROM row address.
- Selects the addressed pixel bit and emits a registered pac_on to the colour mapper.
- Owns the mouth-animation state machine and the frame-synchronous latching of position and direction.

Parameters:
- SPR_SIZE, 32, sprite width/height in pixels; fixed to match the ROM row width.
- ANIM_DIV, 4, number of frame_tick pulses per mouth open/closed toggle (1..15).

Ports:
- Clk  in  1  pixel-domain clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame (start of vertical blank).
- DrawX  in  10  current scan column, 0..639.
- DrawY  in  10  current scan row, 0..479.
- PacX  in  10  requested sprite top-left column.
- PacY  in  10  requested sprite top-left row.
- dir  in  2  requested facing: 0 left, 1 right, 2 up, 3 down.
- moving  in  1  1 = Pac-Man is moving this frame.
- font_addr  out  8  row address to the font ROM.
- font_data  in  32  row bitmap returned combinationally by the ROM; bit 31 is the leftmost pixel.
- pac_on  out  1  registered: the current pixel is a lit Pac-Man pixel.
- mouth_open  out  1  current animation phase, for debug and sound.

Behaviour:
- Reset (asynchronous, Reset_n=0): all registers clear.
  - pac_on=0, mouth_open=1 (state OPEN), font_addr=0.
  - Animation counter=0, latched X/Y=0, latched dir=0.
- Frame latch: on a cycle with frame_tick=1, PacX, PacY, dir and moving are captured into shadow registers. Rendering uses only the shadow values, so the sprite never tears mid-frame.
- Animation FSM, states OPEN and CLOSED, advanced only on frame_tick:
  - If latched moving=0: the counter holds; the state is forced to OPEN on that tick.
  - If moving=1: the counter increments. When it reaches ANIM_DIV-1 it wraps to 0 and the state toggles OPEN<->CLOSED.
  - mouth_open = (state==OPEN), registered.
- Sprite index: CLOSED selects 4. OPEN selects the latched dir (left 0, right 1, up 2, down 3).
- Stage 1 (registered):
  - dx = {1'b0,DrawX} - {1'b0,Xs} and dy likewise, both 11-bit.
  - in_box = (dx < 32) && (dy < 32), with the unsigned compare so negative differences fail.
  - Registers: in_box, row=dy[4:0], col=dx[4:0], sprite index.
- font_addr = {index[2:0], row[4:0]}, driven combinationally from the stage-1 registers.
- Stage 2 (registered): pac_on <= in_box_r & font_data[31-col_r].
- Latency: pac_on corresponds to the DrawX/DrawY presented exactly 2 Clk earlier; the colour mapper delays its own pixel path to match.
- Boundaries:
  - Sprite partially off the right or bottom edge: pixels beyond 639/479 are never scanned, so clipping is implicit.
  - Xs > DrawX: dx wraps large, in_box=0.
  - frame_tick coincident with visible pixels: the new shadow values take effect from the next cycle; a bench must never rely on this.
  - Reset mid-line: pac_on drops to 0 immediately (asynchronous); the first valid pac_on is 2 cycles after release.
  - Indices 5..7 are never generated.

Optional Feature:
- Macro PAC_HFLIP_EN.
- Defined: right-facing uses ROM sprite 0 with the column mirrored, i.e. bit font_data[col_r] instead of font_data[31-col_r]. Sprite index 1 is never addressed, freeing the slot for other art.
- Undefined: right-facing addresses sprite 1 directly, with no mirroring.

Test Plan:
- Reset_n=0 mid-frame for 3 cycles -> pac_on=0, mouth_open=1, font_addr=0 during reset; first valid pac_on 2 cycles after release.
- PacX=100, PacY=200, dir=0, moving=0, frame_tick pulse, then scan DrawY=216, DrawX=96..135 -> font_addr=16; pac_on=1 exactly for DrawX 103..115 (row 16 bits 28..16), delayed 2 cycles; 0 elsewhere.
- moving=1, ANIM_DIV=4, 12 frame_tick pulses -> mouth_open sequence 1,1,1,0,0,0,0,1,1,1,1,0 (toggles on ticks 4, 8, 12); when CLOSED, font_addr upper bits=4.
- moving drops to 0 while CLOSED, next frame_tick -> mouth_open=1, counter frozen.
- dir=3 latched, DrawX=PacX+10, DrawY=PacY+20 -> font_addr=116, pac_on=font_data[21].
- PacX changed from 100 to 300 mid-frame without frame_tick -> sprite remains at 100 until the next frame_tick; PacX=620 -> pixels at DrawX 620..639 render, no wrap to column 0.
